// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle integer ops plus iterative unsigned multiply/divide.
// One operation in flight; operands and results move over valid/ready handshakes.
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [3:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [SHW-1:0]   count;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] quick_result;
  logic             accept_iter;
  logic             accept_div;
  logic             is_mul;
  logic             take_low;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_fits;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign in_ready = (state == IDLE);
  assign Zero     = (ALUResult == '0);

  assign shamt       = SrcB[SHW-1:0];
  assign accept_iter = (ALUControl == OP_MUL)  || (ALUControl == OP_MULHU) ||
                       (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);
  assign accept_div  = (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);
  assign is_mul      = (op == OP_MUL) || (op == OP_MULHU);
  assign take_low    = (op == OP_MUL) || (op == OP_DIVU);

  always_comb begin
    quick_result = '0;
    case (ALUControl)
      OP_ADD:  quick_result = SrcA + SrcB;
      OP_SUB:  quick_result = SrcA - SrcB;
      OP_AND:  quick_result = SrcA & SrcB;
      OP_OR:   quick_result = SrcA | SrcB;
      OP_XOR:  quick_result = SrcA ^ SrcB;
      OP_SLL:  quick_result = SrcA << shamt;
      OP_SRL:  quick_result = SrcA >> shamt;
      OP_SRA:  quick_result = $signed(SrcA) >>> shamt;
      OP_SLT:  quick_result = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      OP_SLTU: quick_result = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      default: quick_result = '0;
    endcase
  end

  // {hi,lo} is shared: product accumulator for multiply, {remainder,quotient} for divide.
  // A zero divisor always "fits", giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, opb});
    div_diff  = div_shift[WIDTH-1:0] - opb;
    step_hi   = hi;
    step_lo   = lo;
    if (is_mul) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (div_fits) begin
      step_hi = div_diff;
      step_lo = {lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = div_shift[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op        <= OP_ADD;
      opa       <= '0;
      opb       <= '0;
      hi        <= '0;
      lo        <= '0;
      count     <= '0;
      ALUResult <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op    <= ALUControl;
            opa   <= SrcA;
            opb   <= SrcB;
            hi    <= '0;
            count <= '0;
            if (accept_iter) begin
              lo    <= accept_div ? SrcA : SrcB;
              state <= BUSY;
            end else begin
              ALUResult <= quick_result;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        // The final step's outputs are loaded straight into the result register.
        BUSY: begin
          hi    <= step_hi;
          lo    <= step_lo;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            ALUResult <= take_low ? step_lo : step_hi;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vectors, randomized ops against a
// behavioural model, backpressure and reset-during-divide scenarios.
module tb_alu_mc;

  localparam int W = 32;
  localparam int ITER_LAT = W + 1;
  localparam int MAX_WAIT = 100;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [3:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         Zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference behaviour computed from the opcode table with plain arithmetic.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    int unsigned    sh;
    prod = 64'(a) * 64'(b);
    sh   = b % W;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return $signed(a) >>> sh;
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return prod[W-1:0];
      4'd11: return prod[2*W-1:W];
      4'd12: return (b == 0) ? {W{1'b1}} : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op);
    return (op >= 4'd10 && op <= 4'd13) ? ITER_LAT : 1;
  endfunction

  // Drives one transaction; lat counts clock edges from the accept edge (inclusive)
  // until out_valid is seen. lat = MAX_WAIT signals a timeout.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic z, output int lat);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < MAX_WAIT) begin
      @(negedge clk);
      waited++;
    end
    res = 'x;
    z   = 1'bx;
    lat = MAX_WAIT;
    if (!in_ready) return;
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    res       = ALUResult;
    z         = Zero;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    SrcA      = '0;
    SrcB      = '0;
    ALUControl = 4'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (ALUResult !== '0) begin n_fail++; $display("[TB] FAIL reset_result got %h want 0", ALUResult); end
    n_checks++;
    if (Zero !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_zero got %b want 1", Zero); end
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  task automatic test_directed();
    vec_t         vecs[$];
    logic [W-1:0] res;
    logic         z;
    int           lat;
    vecs.push_back('{4'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        1});
    vecs.push_back('{4'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1});
    vecs.push_back('{4'd7,  32'h80000000, 32'h24,       32'hF8000000, 1});
    vecs.push_back('{4'd6,  32'h80000000, 32'h24,       32'h08000000, 1});
    vecs.push_back('{4'd8,  32'hFFFFFFFF, 32'h1,        32'h1,        1});
    vecs.push_back('{4'd9,  32'hFFFFFFFF, 32'h1,        32'h0,        1});
    vecs.push_back('{4'd10, 32'h00010000, 32'h00010000, 32'h0,        ITER_LAT});
    vecs.push_back('{4'd11, 32'h00010000, 32'h00010000, 32'h1,        ITER_LAT});
    vecs.push_back('{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        ITER_LAT});
    vecs.push_back('{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ITER_LAT});
    vecs.push_back('{4'd12, 32'd100,      32'd7,        32'd14,       ITER_LAT});
    vecs.push_back('{4'd13, 32'd100,      32'd7,        32'd2,        ITER_LAT});
    vecs.push_back('{4'd12, 32'h1234,     32'h0,        32'hFFFFFFFF, ITER_LAT});
    vecs.push_back('{4'd13, 32'h1234,     32'h0,        32'h1234,     ITER_LAT});
    vecs.push_back('{4'd14, 32'd5,        32'd6,        32'h0,        1});
    vecs.push_back('{4'd15, 32'hABCD,     32'h1,        32'h0,        1});
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
      n_checks++;
      if (res !== vecs[i].exp) begin
        n_fail++;
        $display("[TB] FAIL directed_result[%0d] op=%0d got %h want %h", i, vecs[i].op, res, vecs[i].exp);
      end
      n_checks++;
      if (z !== (vecs[i].exp == '0)) begin
        n_fail++;
        $display("[TB] FAIL directed_zero[%0d] got %b want %b", i, z, vecs[i].exp == '0);
      end
      n_checks++;
      if (lat != vecs[i].lat) begin
        n_fail++;
        $display("[TB] FAIL directed_latency[%0d] got %0d want %0d", i, lat, vecs[i].lat);
      end
    end
  endtask

  task automatic test_random(input int count);
    logic [3:0]   op;
    logic [W-1:0] a, b, exp, res;
    logic         z;
    int           lat;
    for (int i = 0; i < count; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      exp = ref_alu(op, a, b);
      run_op(op, a, b, res, z, lat);
      n_checks++;
      if (res !== exp) begin
        n_fail++;
        $display("[TB] FAIL random_result[%0d] op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, exp);
      end
      n_checks++;
      if (z !== (exp == '0)) begin
        n_fail++;
        $display("[TB] FAIL random_zero[%0d] got %b want %b", i, z, exp == '0);
      end
      n_checks++;
      if (lat != ref_latency(op)) begin
        n_fail++;
        $display("[TB] FAIL random_latency[%0d] op=%0d got %0d want %0d", i, op, lat, ref_latency(op));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res;
    logic         z;
    int           lat;
    @(negedge clk);
    in_valid   = 1'b1;
    ALUControl = 4'd0;
    SrcA       = 32'h10;
    SrcB       = 32'h20;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_out_valid[%0d] got %b want 1", c, out_valid); end
      n_checks++;
      if (ALUResult !== 32'h30) begin n_fail++; $display("[TB] FAIL bp_result[%0d] got %h want 00000030", c, ALUResult); end
      n_checks++;
      if (Zero !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_zero[%0d] got %b want 0", c, Zero); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready[%0d] got %b want 0", c, in_ready); end
      in_valid   = c[0];
      ALUControl = 4'd1;
      SrcA       = $urandom;
      SrcB       = $urandom;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_release_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_in_ready got %b want 1", in_ready); end
    run_op(4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, res, z, lat);
    n_checks++;
    if (res !== 32'hFF00FF00) begin n_fail++; $display("[TB] FAIL bp_next_result got %h want ff00ff00", res); end
    n_checks++;
    if (lat != 1) begin n_fail++; $display("[TB] FAIL bp_next_latency got %0d want 1", lat); end
  endtask

  task automatic test_reset_mid_divide();
    logic [W-1:0] res;
    logic         z;
    int           lat;
    run_op(4'd0, 32'h11, 32'h22, res, z, lat);
    n_checks++;
    if (res !== 32'h33) begin n_fail++; $display("[TB] FAIL rst_pre_result got %h want 00000033", res); end
    @(negedge clk);
    in_valid   = 1'b1;
    ALUControl = 4'd12;
    SrcA       = 32'hDEADBEEF;
    SrcB       = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy_out_valid got %b want 0", out_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_in_ready got %b want 1", in_ready); end
    n_checks++;
    if (ALUResult !== '0) begin n_fail++; $display("[TB] FAIL rst_result got %h want 0", ALUResult); end
    n_checks++;
    if (Zero !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_zero got %b want 1", Zero); end
    run_op(4'd0, 32'd2, 32'd3, res, z, lat);
    n_checks++;
    if (res !== 32'd5) begin n_fail++; $display("[TB] FAIL rst_add_result got %h want 00000005", res); end
    n_checks++;
    if (lat != 1) begin n_fail++; $display("[TB] FAIL rst_add_latency got %0d want 1", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(60);
    test_backpressure();
    test_reset_mid_divide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
